// File: rtl/regfile_pkg.sv
// Shared constants for the 2-write/2-read register file and its read ports.
// Latency: n/a (constants only).  Backpressure: n/a.
package regfile_pkg;
  localparam int RF_DATA_W   = 8;
  localparam int RF_NUM_REGS = 4;
  // Same-address collision between the two write ports resolves to port 1 (late/load writeback).
  localparam bit RF_PORT1_WINS = 1'b1;
endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: address mux, same-cycle write bypass, zero-register masking, busy.
// Latency: 0 cycles (purely combinational).  Backpressure: none; caller stalls on rbusy.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic [DATA_W-1:0]   regs [NUM_REGS],
  input  logic [NUM_REGS-1:0] busy,
  input  logic                we0,
  input  logic [ADDR_W-1:0]   waddr0,
  input  logic [DATA_W-1:0]   wdata0,
  input  logic                we1,
  input  logic [ADDR_W-1:0]   waddr1,
  input  logic [DATA_W-1:0]   wdata1,
  input  logic                claim_en,
  input  logic [ADDR_W-1:0]   claim_addr,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata,
  output logic                rbusy
);

  logic hit0;
  logic hit1;
  logic hit_claim;

  // Write enables arrive already qualified by reset and zero-register dropping.
  always_comb begin
    hit0      = BYPASS && we0 && (waddr0 == raddr);
    hit1      = BYPASS && we1 && (waddr1 == raddr);
    hit_claim = claim_en && (claim_addr == raddr);
    rdata     = regs[raddr];
    rbusy     = busy[raddr];
    if (RF_PORT1_WINS) begin
      if (hit1)      rdata = wdata1;
      else if (hit0) rdata = wdata0;
    end else begin
      if (hit0)      rdata = wdata0;
      else if (hit1) rdata = wdata1;
    end
    // A same-cycle claim keeps the register busy, so the clear is not forwarded then.
    if (hit1 && !hit_claim) rbusy = 1'b0;
    if (ZERO_REG && (raddr == '0)) begin
      rdata = '0;
      rbusy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_2w2r_sb.sv
// Register file with two write ports, two bypassing read ports and a per-register busy scoreboard.
// Latency: writes/claims commit at the edge; reads are combinational.  Backpressure: none.
module regfile_2w2r_sb
  import regfile_pkg::*;
#(
  parameter int  DATA_W   = RF_DATA_W,
  parameter int  NUM_REGS = RF_NUM_REGS,
  parameter bit  BYPASS   = 1'b1,
  parameter bit  ZERO_REG = 1'b0,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we0,
  input  logic [ADDR_W-1:0]   waddr0,
  input  logic [DATA_W-1:0]   wdata0,
  input  logic                we1,
  input  logic [ADDR_W-1:0]   waddr1,
  input  logic [DATA_W-1:0]   wdata1,
  input  logic                claim_en,
  input  logic [ADDR_W-1:0]   claim_addr,
  input  logic [ADDR_W-1:0]   raddr_a,
  input  logic [ADDR_W-1:0]   raddr_b,
  output logic [DATA_W-1:0]   rdata_a,
  output logic [DATA_W-1:0]   rdata_b,
  output logic                rbusy_a,
  output logic                rbusy_b,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                we0_ok;
  logic                we1_ok;
  logic                claim_ok;

  // Reset blocks commits and bypass alike; register 0 is write/claim-proof when hardwired.
  always_comb begin
    we0_ok   = !reset && we0      && !(ZERO_REG && (waddr0 == '0));
    we1_ok   = !reset && we1      && !(ZERO_REG && (waddr1 == '0));
    claim_ok = !reset && claim_en && !(ZERO_REG && (claim_addr == '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (RF_PORT1_WINS) begin
        if (we0_ok) regs[waddr0] <= wdata0;
        if (we1_ok) regs[waddr1] <= wdata1;
      end else begin
        if (we1_ok) regs[waddr1] <= wdata1;
        if (we0_ok) regs[waddr0] <= wdata0;
      end
      // Claim is applied last so a same-address claim beats the port-1 clear.
      if (we1_ok)   busy[waddr1]     <= 1'b0;
      if (claim_ok) busy[claim_addr] <= 1'b1;
    end
  end

  always_comb begin
    busy_vec = busy;
    if (ZERO_REG) busy_vec[0] = 1'b0;
  end

  rf_read_port #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
  ) u_rd_a (
    .regs(regs), .busy(busy),
    .we0(we0_ok), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1_ok), .waddr1(waddr1), .wdata1(wdata1),
    .claim_en(claim_ok), .claim_addr(claim_addr),
    .raddr(raddr_a), .rdata(rdata_a), .rbusy(rbusy_a)
  );

  rf_read_port #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
  ) u_rd_b (
    .regs(regs), .busy(busy),
    .we0(we0_ok), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1_ok), .waddr1(waddr1), .wdata1(wdata1),
    .claim_en(claim_ok), .claim_addr(claim_addr),
    .raddr(raddr_b), .rdata(rdata_b), .rbusy(rbusy_b)
  );

endmodule
